// File: rtl/cpu_pkg.sv
// cpu_pkg: memory-access encodings, port FSM states, load/store opcodes
// and the load-byte extend helper shared by the core and data_mem_port.
package cpu_pkg;
    localparam logic MEMC_BYTE = 1'b0;
    localparam logic MEMC_WORD = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        LAST = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam logic [5:0] OP_LB = 6'b100000;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SW = 6'b101011;

    function automatic logic [15:0] ext_byte(input logic [7:0] b, input logic signed_en);
        return {{8{signed_en & b[7]}}, b};
    endfunction
endpackage

// File: rtl/data_mem_port.sv
// data_mem_port: serialises one lb/lw/sb/sw request onto an 8-bit synchronous RAM,
// little-endian, and returns a registered ready/err pulse plus extended load data.
module data_mem_port
    import cpu_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter bit LB_SIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wmem,
    input  logic              memc,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata,
    output logic              ready,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    state_t            state, state_nxt;
    logic              wmem_q, memc_q, mis_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [7:0]        lo_q;
    logic              mis_in;

    assign mis_in = (memc == MEMC_WORD) & addr[0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = !req ? IDLE : mis_in ? RESP : LO;
            LO:      state_nxt = (memc_q == MEMC_WORD) ? HI : wmem_q ? RESP : LAST;
            HI:      state_nxt = wmem_q ? RESP : LAST;
            LAST:    state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM strobes come only from state and latched request, so reset kills them at once
    assign mem_en    = (state == LO) || (state == HI);
    assign mem_we    = mem_en & wmem_q;
    assign mem_wdata = !mem_we ? 8'h00 : (state == HI) ? wdata_q[15:8] : wdata_q[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wmem_q   <= 1'b0;
            memc_q   <= 1'b0;
            mis_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 16'h0000;
            lo_q     <= 8'h00;
            rdata    <= 16'h0000;
            ready    <= 1'b0;
            err      <= 1'b0;
            mem_addr <= '0;
        end else begin
            state <= state_nxt;
            ready <= (state == RESP);
            err   <= (state == RESP) & mis_q;
            if (state == IDLE && req) begin
                wmem_q  <= wmem;
                memc_q  <= memc;
                mis_q   <= mis_in;
                addr_q  <= addr;
                wdata_q <= wdata;
                if (!mis_in)
                    mem_addr <= addr;
            end
            if (state == LO && memc_q == MEMC_WORD)
                mem_addr <= addr_q + ADDR_W'(1);
            if (state == HI)
                lo_q <= mem_rdata;
            // whole word is committed in one edge so no half-updated value is visible
            if (state == LAST)
                rdata <= (memc_q == MEMC_WORD) ? {mem_rdata, lo_q} : ext_byte(mem_rdata, LB_SIGNED);
        end
    end
endmodule

// File: tb/tb_data_mem_port.sv
// tb_data_mem_port: directed checks of data_mem_port against a byte RAM model,
// with a zero-extending instance alongside for the lb extend option.
module tb_data_mem_port;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, wmem = 1'b0, memc = 1'b0;
    logic [15:0] addr = 16'h0000, wdata = 16'h0000;
    logic [15:0] rdata, u_rdata;
    logic        ready, err, u_ready, u_err;
    logic        mem_en, mem_we, u_mem_en, u_mem_we;
    logic [15:0] mem_addr, u_mem_addr;
    logic [7:0]  mem_wdata, u_mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  ram [0:65535];
    logic [15:0] en_log [$];
    int          we_cnt = 0, en_cnt = 0, rdy_cnt = 0;
    int          n_cmp = 0, n_bad = 0;
    int          lat, base_en, base_we, base_rdy;

    always #5 clk = ~clk;

    data_mem_port #(.ADDR_W(16), .LB_SIGNED(1'b1)) dut (
        .clk(clk), .rst(rst), .req(req), .wmem(wmem), .memc(memc), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ready(ready), .err(err), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    data_mem_port #(.ADDR_W(16), .LB_SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .req(req), .wmem(wmem), .memc(memc), .addr(addr),
        .wdata(wdata), .rdata(u_rdata), .ready(u_ready), .err(u_err), .mem_en(u_mem_en),
        .mem_we(u_mem_we), .mem_addr(u_mem_addr), .mem_wdata(u_mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                ram[mem_addr] <= mem_wdata;
            else
                mem_rdata <= ram[mem_addr];
        end
    end

    always @(negedge clk) begin
        if (mem_we) we_cnt++;
        if (mem_en) begin
            en_cnt++;
            en_log.push_back(mem_addr);
        end
        if (ready) rdy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(output int l);
        l = 0;
        while (!ready && l < 12) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic run(input logic w, input logic m, input logic [15:0] a, input logic [15:0] d,
                       output int l);
        @(negedge clk);
        req = 1'b1; wmem = w; memc = m; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
        wait_ready(l);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0031] = 8'hC3;
        ram[16'h0040] = 8'h11;
        ram[16'h0041] = 8'h22;
        #12;
        chk("rst_ready", ready, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_wdata", mem_wdata, 8'h00);
        @(negedge clk) rst = 1'b0;

        base_we = we_cnt;
        run(1'b1, 1'b0, 16'h0010, 16'h12AB, lat);
        chk("sb_lat", lat, 2);
        chk("sb_err", err, 1'b0);
        @(posedge clk); #1;
        chk("sb_ready_1cyc", ready, 1'b0);
        chk("sb_ram10", ram[16'h0010], 8'hAB);
        chk("sb_we_cycles", we_cnt - base_we, 1);

        run(1'b1, 1'b1, 16'h0020, 16'hBEEF, lat);
        chk("sw_lat", lat, 3);
        chk("sw_ram20", ram[16'h0020], 8'hEF);
        chk("sw_ram21", ram[16'h0021], 8'hBE);

        run(1'b0, 1'b1, 16'h0020, 16'h0000, lat);
        chk("lw_lat", lat, 4);
        chk("lw_rdata", rdata, 16'hBEEF);
        chk("lw_err", err, 1'b0);

        run(1'b0, 1'b0, 16'h0021, 16'h0000, lat);
        chk("lb_lat", lat, 3);
        chk("lb_signed", rdata, 16'hFFBE);
        chk("lb_unsigned", u_rdata, 16'h00BE);

        base_en = en_cnt;
        run(1'b0, 1'b1, 16'h0023, 16'h0000, lat);
        chk("mis_lat", lat, 1);
        chk("mis_err", err, 1'b1);
        chk("mis_no_access", en_cnt - base_en, 0);
        chk("mis_rdata_held", rdata, 16'hFFBE);

        base_en = en_cnt;
        @(negedge clk);
        req = 1'b1; wmem = 1'b0; memc = 1'b1; addr = 16'h0020;
        @(posedge clk);
        #1 addr = 16'h0040;
        wait_ready(lat);
        chk("held_lat", lat, 4);
        chk("held_rdata", rdata, 16'hBEEF);
        chk("held_accesses", en_cnt - base_en, 2);
        chk("held_addr0", en_log[base_en], 16'h0020);
        chk("held_addr1", en_log[base_en+1], 16'h0021);
        @(posedge clk); #1;
        chk("held_next_en", mem_en, 1'b1);
        chk("held_next_addr", mem_addr, 16'h0040);
        req = 1'b0;
        wait_ready(lat);
        chk("held_next_lat", lat, 4);
        chk("held_next_rdata", rdata, 16'h2211);

        run(1'b1, 1'b1, 16'hFFFE, 16'h1234, lat);
        chk("wrap_lat", lat, 3);
        chk("wrap_ramFFFE", ram[16'hFFFE], 8'h34);
        chk("wrap_ramFFFF", ram[16'hFFFF], 8'h12);

        @(negedge clk);
        req = 1'b1; wmem = 1'b1; memc = 1'b1; addr = 16'h0030; wdata = 16'h5566;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_in_hi_we", mem_we, 1'b1);
        base_rdy = rdy_cnt;
        rst = 1'b1;
        #1;
        chk("rst_mid_we_drop", mem_we, 1'b0);
        chk("rst_mid_en_drop", mem_en, 1'b0);
        chk("rst_mid_rdata", rdata, 16'h0000);
        @(negedge clk) rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_mid_no_ready", rdy_cnt - base_rdy, 0);
        chk("rst_mid_ram30", ram[16'h0030], 8'h66);
        chk("rst_mid_ram31", ram[16'h0031], 8'hC3);

        run(1'b0, 1'b0, 16'h0030, 16'h0000, lat);
        chk("post_rst_lb_lat", lat, 3);
        chk("post_rst_lb_rdata", rdata, 16'h0066);
        chk("post_rst_lb_err", err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
